// File: rtl/ifm_bitplane_serializer_if.sv
// Upstream vector handshake and downstream bit-plane stream of the IFM serializer.
interface ifm_bitplane_serializer_if #(
    parameter int NPIX = 32,
    parameter int BITS = 4
);
    localparam int KW = (BITS > 1) ? $clog2(BITS) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [NPIX*BITS-1:0] In_VEC;
    logic                 out_valid;
    logic [NPIX-1:0]      Out_IFM;
    logic [KW-1:0]        bit_idx;
    logic                 out_last;

    modport master (
        output in_valid, In_VEC,
        input  in_ready, out_valid, Out_IFM, bit_idx, out_last
    );

    modport slave (
        input  in_valid, In_VEC,
        output in_ready, out_valid, Out_IFM, bit_idx, out_last
    );
endinterface

// File: rtl/ifm_bitplane_serializer.sv
// Buffers pixel vectors in a 2-entry FIFO and streams each one out as BITS
// bit-planes, LSB plane first, with no bubbles between queued vectors.
module ifm_bitplane_serializer #(
    parameter int NPIX = 32,
    parameter int BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    ifm_bitplane_serializer_if.slave      ifm
);
    localparam int KW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int VW = NPIX * BITS;
    localparam logic [KW-1:0] K_LAST = KW'(BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          r_state;
    logic [VW-1:0]   r_fifo [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic [VW-1:0]   r_shreg;
    logic [NPIX-1:0] r_plane;
    logic [KW-1:0]   r_bit;
    logic            r_valid;
    logic            r_last;

    logic            w_in_ready;
    logic            w_push;
    logic            w_slot;
    logic            w_load;
    logic            w_pop;
    logic            w_fifo_wr;
    logic [VW-1:0]   w_next_vec;
    logic [VW-1:0]   w_shifted;

    function automatic logic [NPIX-1:0] lsb_plane(input logic [VW-1:0] v);
        logic [NPIX-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < NPIX; i++) begin
            p[i] = v[BITS*i];
        end
        return p;
    endfunction

    function automatic logic [VW-1:0] pixel_shr(input logic [VW-1:0] v);
        logic [VW-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < NPIX; i++) begin
            s[BITS*i +: BITS] = v[BITS*i +: BITS] >> 1;
        end
        return s;
    endfunction

    assign w_in_ready = !rst && (r_count != 2'd2);
    assign w_push     = ifm.in_valid && w_in_ready;
    // A new vector may start from IDLE or on the edge leaving the last plane.
    assign w_slot     = (r_state == IDLE) || (r_bit == K_LAST);
    assign w_load     = w_slot && ((r_count != 2'd0) || w_push);
    assign w_pop      = w_load && (r_count != 2'd0);
    // Bypass: a vector accepted into an empty FIFO while a slot is open goes straight to the shifter.
    assign w_fifo_wr  = w_push && !(w_load && (r_count == 2'd0));
    assign w_next_vec = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : ifm.In_VEC;
    assign w_shifted  = pixel_shr(r_shreg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= '0;
            r_shreg   <= '0;
            r_plane   <= '0;
            r_bit     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            if (w_fifo_wr) begin
                r_fifo[r_wr_ptr] <= ifm.In_VEC;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_fifo_wr) - 2'(w_pop);

            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state <= SHIFT;
                        r_shreg <= w_next_vec;
                        r_plane <= lsb_plane(w_next_vec);
                        r_bit   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (BITS == 1);
                    end else begin
                        r_shreg <= '0;
                        r_plane <= '0;
                        r_bit   <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!w_slot) begin
                        r_shreg <= w_shifted;
                        r_plane <= lsb_plane(w_shifted);
                        r_bit   <= r_bit + KW'(1);
                        r_last  <= (KW'(r_bit + KW'(1)) == K_LAST);
                    end else if (w_load) begin
                        r_shreg <= w_next_vec;
                        r_plane <= lsb_plane(w_next_vec);
                        r_bit   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (BITS == 1);
                    end else begin
                        r_state <= IDLE;
                        r_shreg <= '0;
                        r_plane <= '0;
                        r_bit   <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ifm.in_ready  = w_in_ready;
    assign ifm.out_valid = r_valid;
    assign ifm.Out_IFM   = r_plane;
    assign ifm.bit_idx   = r_bit;
    assign ifm.out_last  = r_last;
endmodule

// File: tb/tb_ifm_bitplane_serializer.sv
// Randomized bench for ifm_bitplane_serializer against a schedule-based reference model.
module tb_ifm_bitplane_serializer;
    localparam int NPIX = 32;
    localparam int BITS = 4;
    localparam int KW   = 2;
    localparam int VW   = NPIX * BITS;
    localparam int W    = 3 + KW + NPIX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifm_bitplane_serializer_if #(.NPIX(NPIX), .BITS(BITS)) bus();
    ifm_bitplane_serializer #(.NPIX(NPIX), .BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .ifm (bus)
    );

    // Each accepted vector owns the BITS output cycles starting at edge 'start'.
    typedef struct {
        logic [VW-1:0] vec;
        int            start;
    } rec_t;

    rec_t recs[$];
    int   edge_n    = 0;
    int   next_free = 0;
    int   total     = 0;
    int   bad       = 0;

    function automatic logic [NPIX-1:0] plane_of(input logic [VW-1:0] v, input int k);
        logic [NPIX-1:0] p;
        for (int i = 0; i < NPIX; i++) p[i] = v[BITS*i + k];
        return p;
    endfunction

    function automatic logic [W-1:0] exp_word();
        logic            v;
        logic            last;
        logic [KW-1:0]   k;
        logic [NPIX-1:0] p;
        int              occ;
        v = 1'b0; last = 1'b0; k = '0; p = '0; occ = 0;
        foreach (recs[j]) begin
            if (recs[j].start <= edge_n && edge_n < recs[j].start + BITS) begin
                v    = 1'b1;
                k    = KW'(edge_n - recs[j].start);
                p    = plane_of(recs[j].vec, edge_n - recs[j].start);
                last = (edge_n - recs[j].start == BITS - 1);
            end
            if (recs[j].start > edge_n) occ++;
        end
        return {v, last, k, p, (!rst && occ < 2)};
    endfunction

    function automatic logic [W-1:0] obs_word();
        return {bus.out_valid, bus.out_last, bus.bit_idx, bus.Out_IFM, bus.in_ready};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < VW / 32; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        recs.delete();
        next_free = 0;
    endtask

    // Drives one cycle from a negedge to the next negedge and updates the model.
    task automatic cycle(input logic v, input logic [VW-1:0] vec, output logic acc);
        bus.in_valid = v;
        bus.In_VEC   = vec;
        acc = v && bus.in_ready && !rst;
        @(posedge clk);
        edge_n++;
        if (acc) begin
            int s;
            s = (edge_n > next_free) ? edge_n : next_free;
            recs.push_back('{vec, s});
            next_free = s + BITS;
        end
        while (recs.size() > 0 && recs[0].start + BITS <= edge_n) void'(recs.pop_front());
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W-1:0] got, want;
        logic a;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.In_VEC   = '1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_hold got=%h exp=%h", got, want);
            end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        edge_n = 0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
        end
        @(negedge clk);
        cycle(1'b0, '0, a);
        got = obs_word(); want = exp_word();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=%h", got, want);
        end
    endtask

    task automatic test_all_ones();
        logic [W-1:0] got, want;
        logic a;
        int nv;
        nv = 0;
        for (int c = 0; c < 7; c++) begin
            cycle(c == 0, '1, a);
            got = obs_word(); want = exp_word();
            if (bus.out_valid === 1'b1) nv++;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL all_ones edge=%0d got=%h exp=%h", edge_n, got, want);
            end
        end
        total++;
        if (nv !== 4) begin
            bad++;
            $display("FAIL all_ones_count got=%0d exp=4", nv);
        end
    endtask

    task automatic test_pattern();
        logic [W-1:0]    got, want;
        logic [VW-1:0]   vec;
        logic [NPIX-1:0] planes [4];
        logic a;
        planes[0] = 32'h0000_0001;
        planes[1] = 32'h0000_0000;
        planes[2] = 32'h0000_0001;
        planes[3] = 32'h8000_0000;
        vec = '0;
        vec[3:0]     = 4'b0101;
        vec[127:124] = 4'b1000;
        cycle(1'b1, vec, a);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.Out_IFM !== planes[k] || bus.bit_idx !== KW'(k) || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL pattern_plane k=%0d got=%h/%0d exp=%h/%0d", k, bus.Out_IFM, bus.bit_idx, planes[k], k);
            end
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL pattern edge=%0d got=%h exp=%h", edge_n, got, want);
            end
            cycle(1'b0, '0, a);
        end
        got = obs_word(); want = exp_word();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL pattern_end edge=%0d got=%h exp=%h", edge_n, got, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  got, want;
        logic [VW-1:0] cur;
        logic a;
        int n, budget, nv, low_seen;
        n = 0; budget = 20; nv = 0; low_seen = 0;
        cur = rand_vec();
        while (n < 3 && budget > 0) begin
            cycle(1'b1, cur, a);
            if (a) begin n++; cur = rand_vec(); end
            if (bus.in_ready === 1'b0) low_seen = 1;
            if (bus.out_valid === 1'b1) nv++;
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b edge=%0d got=%h exp=%h", edge_n, got, want);
            end
            budget--;
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL b2b_timeout accepted=%0d exp=3", n);
        end
        repeat (14) begin
            cycle(1'b0, '0, a);
            if (bus.out_valid === 1'b1) nv++;
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b_drain edge=%0d got=%h exp=%h", edge_n, got, want);
            end
        end
        total++;
        if (nv !== 12 || low_seen !== 1) begin
            bad++;
            $display("FAIL b2b_summary valid_cycles=%0d ready_low=%0d exp=12/1", nv, low_seen);
        end
    endtask

    task automatic test_gap();
        logic [W-1:0] got, want;
        logic a;
        for (int c = 0; c < 14; c++) begin
            cycle(c == 0 || c == 7, rand_vec(), a);
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL gap edge=%0d got=%h exp=%h", edge_n, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got, want;
        logic a;
        cycle(1'b1, rand_vec(), a);
        cycle(1'b1, rand_vec(), a);
        cycle(1'b0, '0, a);
        total++;
        if (bus.bit_idx !== KW'(2) || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_setup got=%0d/%b exp=2/1", bus.bit_idx, bus.out_valid);
        end
        rst = 1'b1;
        #1;
        got = obs_word();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL rstmid_async got=%h exp=0", got);
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready got=%b exp=1", bus.in_ready);
        end
        repeat (8) begin
            cycle(1'b0, '0, a);
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rstmid_quiet edge=%0d got=%h exp=%h", edge_n, got, want);
            end
        end
    endtask

    task automatic test_full_hold();
        logic [W-1:0]  got, want;
        logic [VW-1:0] cur;
        logic a;
        int n, budget, stalled;
        n = 0; budget = 30; stalled = 0;
        cur = rand_vec();
        // While stalled, junk is presented; a fresh vector is presented only when in_ready is high.
        while (n < 4 && budget > 0) begin
            if (bus.in_ready !== 1'b1) begin
                stalled++;
                cycle(1'b1, rand_vec(), a);
            end else begin
                cycle(1'b1, cur, a);
            end
            if (a) begin n++; cur = rand_vec(); end
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL full edge=%0d got=%h exp=%h", edge_n, got, want);
            end
            budget--;
        end
        total++;
        if (n !== 4 || stalled == 0) begin
            bad++;
            $display("FAIL full_progress accepted=%0d stalled=%0d exp=4/>0", n, stalled);
        end
        repeat (18) begin
            cycle(1'b0, '0, a);
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL full_drain edge=%0d got=%h exp=%h", edge_n, got, want);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] got, want;
        logic a;
        for (int c = 0; c < 300; c++) begin
            cycle(c < 290 && $urandom_range(0, 2) != 0, rand_vec(), a);
            got = obs_word(); want = exp_word();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random edge=%0d got=%h exp=%h", edge_n, got, want);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.In_VEC   = '0;
        test_reset();
        test_all_ones();
        test_pattern();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_full_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ifm_bitplane_serializer.md
IFM_BITPLANE_SERIALIZER -- requirements
Module: ifm_bitplane_serializer

Interface
REQ-001 SHALL have parameter NPIX, default 32, meaning pixels per vector and width of each bit-plane.
REQ-002 SHALL have parameter BITS, default 4, meaning bits per pixel and bit-planes emitted per vector.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, an upstream vector is presented.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a vector this cycle.
REQ-007 SHALL have port In_VEC, input, NPIX*BITS, with pixel i in bits [BITS*i+BITS-1 : BITS*i].
REQ-008 SHALL have port out_valid, output, 1, which drives the convolution core's in_valid.
REQ-009 SHALL have port Out_IFM, output, NPIX, the current bit-plane; bit i is bit k of pixel i.
REQ-010 SHALL have port bit_idx, output, clog2(BITS), the plane index k of Out_IFM.
REQ-011 SHALL have port out_last, output, 1, high when the final plane of a vector is on Out_IFM (k = BITS-1).

Function
REQ-012 SHALL accept a vector on any rising edge where in_valid and in_ready are both high; the vector is written into a 2-entry FIFO.
REQ-013 SHALL drive in_ready high exactly when FIFO occupancy is below 2 and rst is low; in_ready SHALL NOT depend combinationally on in_valid.
REQ-014 SHALL implement an FSM with states IDLE and SHIFT; the state resets to IDLE.
REQ-015 IDLE -> SHIFT: on an edge where the FIFO is non-empty, or a vector is being accepted into an empty FIFO; the head vector is popped into a shift register, bit_idx is set to 0, and out_valid is registered high.
REQ-016 Latency: a vector accepted at edge T into an idle, empty block SHALL have plane 0 on Out_IFM from edge T+1, with the FIFO bypassed.
REQ-017 In SHIFT, each edge SHALL advance bit_idx by 1 and present the next plane; planes are emitted LSB first (k = 0..BITS-1), and out_valid stays high for exactly BITS consecutive cycles per vector.
REQ-018 On the edge leaving k = BITS-1: if a vector is available (FIFO non-empty, or one is accepted on that edge into an empty FIFO), the block SHALL load it and present its plane 0 on the next cycle with no bubble and remain in SHIFT; otherwise it SHALL go to IDLE.
REQ-019 On going to IDLE, out_valid, out_last and bit_idx SHALL be 0, and Out_IFM SHALL be held at 0 whenever out_valid is low.
REQ-020 A simultaneous push and pop SHALL leave occupancy unchanged, and FIFO order SHALL be strictly first-in first-out.
REQ-021 At full occupancy (2), in_ready SHALL be low and In_VEC SHALL be ignored, even if in_valid is high.
REQ-022 A vector once started SHALL never be interrupted or stalled; the downstream core has no back-pressure.
REQ-023 bit_idx SHALL wrap BITS-1 -> 0 only at a vector boundary.

Reset
REQ-024 While rst is high, the block SHALL asynchronously force state IDLE, FIFO empty, out_valid=0, out_last=0, bit_idx=0, Out_IFM=0, and in_ready=0.
REQ-025 After rst deasserts, in_ready SHALL be 1 on the first edge.
REQ-026 Reset mid-vector SHALL discard the partially emitted vector and all FIFO contents; no further planes of those vectors SHALL ever appear.

Verification
REQ-027 Push all pixels = 4'hF with the block idle -> four cycles of Out_IFM = 32'hFFFFFFFF, bit_idx 0,1,2,3, out_last only on the 4th, then out_valid = 0.
REQ-028 Push pixel0 = 4'b0101, pixel31 = 4'b1000, others 0 -> Out_IFM = 32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000.
REQ-029 Push 3 vectors back-to-back with in_valid held high -> 12 consecutive out_valid cycles with no gap; in_ready drops while occupancy is 2; the order of the vectors is preserved.
REQ-030 Push vector A, idle 6 cycles, then push vector B -> two separate 4-cycle bursts, with out_valid = 0 and Out_IFM = 0 in between.
REQ-031 Assert rst at bit_idx = 2 with 1 vector queued -> out_valid = 0 immediately; after release, in_ready = 1 and there is no output until a new push.
REQ-032 Hold in_valid high while full -> the vector presented is not accepted, and the vector that is accepted once in_ready returns high is emitted exactly once.
